// File: rtl/voice_scheduler.sv
// voice_scheduler: SPI note events -> event FIFO -> handshaked voice bank writes.
// Optional ack watchdog and o_timeout port: `define VOICE_SCHED_TIMEOUT_EN.
module voice_scheduler #(
    parameter int NUM_VOICES  = 16,
    parameter int VI_W        = 4,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_SPI_flag,
    input  logic                  i_SPI_note_status,
    input  logic [7:0]            i_SPI_voice_index,
    input  logic [31:0]           i_SPI_tuning_code,
    input  logic [6:0]            i_SPI_velocity,
    output logic                  o_voice_wr_en,
    output logic [VI_W-1:0]       o_voice_wr_addr,
    output logic [31:0]           o_voice_tuning,
    output logic [6:0]            o_voice_velocity,
    output logic                  o_voice_gate,
    input  logic                  i_voice_wr_ack,
    output logic [NUM_VOICES-1:0] o_gate_mask,
    output logic [VI_W:0]         o_active_count,
    output logic                  o_overflow,
    output logic                  o_bad_index,
`ifdef VOICE_SCHED_TIMEOUT_EN
    output logic                  o_timeout,
`endif
    output logic                  o_busy
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + VI_W + 32 + 7;
    localparam int AC_W  = VI_W + 1;
    localparam logic [8:0]       NV    = 9'(NUM_VOICES);
    localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

    if (VI_W != $clog2(NUM_VOICES) || TIMEOUT_CYC < 1) begin : g_param_chk
        $error("voice_scheduler: inconsistent parameters");
    end

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                r_state, w_state_next;
    logic                  r_flag_q;
    logic [ENT_W-1:0]      r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      r_wp, r_rp;
    logic [CNT_W-1:0]      r_cnt, w_cnt_next;
    logic                  w_event, w_idx_ok, w_full;
    logic                  w_push, w_pop, w_done, w_tmo;
    logic [ENT_W-1:0]      w_wdata, w_head;
    logic [NUM_VOICES-1:0] r_mask, w_mask_next;
    logic [AC_W-1:0]       r_count, w_count_next;
    logic                  r_wr_en, r_gate, r_ovf, r_bad, r_busy;
    logic [VI_W-1:0]       r_addr;
    logic [31:0]           r_tuning;
    logic [6:0]            r_vel;

    assign w_event  = i_SPI_flag & ~r_flag_q;
    assign w_idx_ok = {1'b0, i_SPI_voice_index} < NV;
    assign w_full   = (r_cnt == DEPTH);
    assign w_push   = w_event & w_idx_ok & (~w_full | w_pop);
    assign w_head   = r_mem[r_rp];

    // Note-off entries carry no tuning/velocity payload.
    assign w_wdata = {i_SPI_note_status,
                      i_SPI_voice_index[VI_W-1:0],
                      i_SPI_note_status ? i_SPI_tuning_code : 32'd0,
                      i_SPI_note_status ? i_SPI_velocity : 7'd0};

    assign w_cnt_next = r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);

`ifdef VOICE_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             w_tmo_hit, r_timeout;

    // Counts completed cycles in WRITE; fires on the TIMEOUT_CYC-th one.
    assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
    assign o_timeout = r_timeout;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (w_pop)
                r_tmo_cnt <= '0;
            else if (r_state == WRITE)
                r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (w_tmo)
                r_timeout <= 1'b1;
        end
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_pop        = 1'b0;
        w_done       = 1'b0;
        w_tmo        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (r_cnt != '0) begin
                    w_pop        = 1'b1;
                    w_state_next = WRITE;
                end
            end
            WRITE: begin
                if (i_voice_wr_ack) begin
                    w_done       = 1'b1;
                    w_state_next = IDLE;
                end
`ifdef VOICE_SCHED_TIMEOUT_EN
                else if (w_tmo_hit) begin
                    w_tmo        = 1'b1;
                    w_state_next = IDLE;
                end
`endif
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_push)
            r_mem[r_wp] <= w_wdata;
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_flag_q <= 1'b0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
        end else begin
            r_flag_q <= i_SPI_flag;
            if (w_push)
                r_wp <= r_wp + PTR_W'(1);
            if (w_pop)
                r_rp <= r_rp + PTR_W'(1);
            r_cnt <= w_cnt_next;
        end
    end

    always_comb begin
        w_mask_next = r_mask;
        if (w_done)
            w_mask_next[r_addr] = r_gate;
        w_count_next = '0;
        for (int i = 0; i < NUM_VOICES; i++)
            w_count_next = w_count_next + AC_W'(w_mask_next[i]);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_en  <= 1'b0;
            r_addr   <= '0;
            r_tuning <= '0;
            r_vel    <= '0;
            r_gate   <= 1'b0;
            r_mask   <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_bad    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_wr_en <= 1'b1;
                {r_gate, r_addr, r_tuning, r_vel} <= w_head;
            end else if (w_done | w_tmo) begin
                r_wr_en <= 1'b0;
            end
            r_mask  <= w_mask_next;
            r_count <= w_count_next;
            r_busy  <= (w_cnt_next != '0) | (w_state_next != IDLE);
            if (w_event & ~w_idx_ok)
                r_bad <= 1'b1;
            if (w_event & w_idx_ok & w_full & ~w_pop)
                r_ovf <= 1'b1;
        end
    end

    assign o_voice_wr_en    = r_wr_en;
    assign o_voice_wr_addr  = r_addr;
    assign o_voice_tuning   = r_tuning;
    assign o_voice_velocity = r_vel;
    assign o_voice_gate     = r_gate;
    assign o_gate_mask      = r_mask;
    assign o_active_count   = r_count;
    assign o_overflow       = r_ovf;
    assign o_bad_index      = r_bad;
    assign o_busy           = r_busy;

endmodule
